// File: rtl/audio_tone_mixer_if.sv
// Sample handshake bus between the tone mixer and Audio_Controller.
// The mixer owns read/write and the output samples; the controller side
// provides availability flags and the passthrough input samples.
interface audio_tone_mixer_if #(
    parameter int SAMPLE_W = 32
);
    logic                       audio_in_available;
    logic                       audio_out_allowed;
    logic signed [SAMPLE_W-1:0] left_channel_audio_in;
    logic signed [SAMPLE_W-1:0] right_channel_audio_in;
    logic                       read_audio_in;
    logic                       write_audio_out;
    logic signed [SAMPLE_W-1:0] left_channel_audio_out;
    logic signed [SAMPLE_W-1:0] right_channel_audio_out;

    modport master (
        input  audio_in_available,
        input  audio_out_allowed,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        output audio_in_available,
        output audio_out_allowed,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );
endinterface

// File: rtl/audio_tone_mixer.sv
// Multi-voice one-shot square-wave tone generator mixed onto the mic/line
// passthrough. Each voice latches pitch, amplitude and length on its trigger,
// plays for a fixed number of transferred samples, then goes quiet. The sum
// of all voices is added to both channels with saturation.
module audio_tone_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 32,
    parameter int PERIOD_W   = 19,
    parameter int DUR_W      = 16,
    parameter int AMP_W      = 24
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic [NUM_VOICES-1:0]          trig,
    input  logic [NUM_VOICES*PERIOD_W-1:0] half_period,
    input  logic [NUM_VOICES*DUR_W-1:0]    duration,
    input  logic [NUM_VOICES*AMP_W-1:0]    amplitude,
    input  logic                           mute,
    output logic [NUM_VOICES-1:0]          busy,
    audio_tone_mixer_if.master             audio_bus
);

    localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int SUM_W = MIX_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } voice_state_t;

    voice_state_t              state_q [NUM_VOICES];
    logic [PERIOD_W-1:0]       hp_q    [NUM_VOICES];
    logic [PERIOD_W-1:0]       phase_q [NUM_VOICES];
    logic [DUR_W-1:0]          dur_q   [NUM_VOICES];
    logic [AMP_W-1:0]          amp_q   [NUM_VOICES];
    logic                      pol_q   [NUM_VOICES];
    logic signed [MIX_W-1:0]   mix_next;
    logic signed [MIX_W-1:0]   mix_reg;
    logic signed [SUM_W-1:0]   left_sum;
    logic signed [SUM_W-1:0]   right_sum;
    logic                      xfer;

    // A sample moves only when the controller can both give and take one,
    // so input pops and output pushes always pair up.
    assign xfer = audio_bus.audio_in_available & audio_bus.audio_out_allowed & resetn;
    assign audio_bus.read_audio_in   = xfer;
    assign audio_bus.write_audio_out = xfer;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[SAMPLE_W-1:0];
    endfunction

    // Per-voice IDLE/PLAY state, field latches, square-wave phase and sample countdown.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= IDLE;
                hp_q[i]    <= '0;
                phase_q[i] <= '0;
                dur_q[i]   <= '0;
                amp_q[i]   <= '0;
                pol_q[i]   <= 1'b1;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (trig[i]) begin
                    if (duration[i*DUR_W +: DUR_W] != '0) begin
                        state_q[i] <= PLAY;
                        busy[i]    <= 1'b1;
                        hp_q[i]    <= half_period[i*PERIOD_W +: PERIOD_W];
                        dur_q[i]   <= duration[i*DUR_W +: DUR_W];
                        amp_q[i]   <= amplitude[i*AMP_W +: AMP_W];
                        phase_q[i] <= '0;
                        pol_q[i]   <= 1'b1;
                    end else begin
                        state_q[i] <= IDLE;
                        busy[i]    <= 1'b0;
                    end
                end else if (state_q[i] == PLAY) begin
                    if (phase_q[i] == hp_q[i]) begin
                        phase_q[i] <= '0;
                        pol_q[i]   <= ~pol_q[i];
                    end else begin
                        phase_q[i] <= phase_q[i] + PERIOD_W'(1);
                    end
                    if (xfer) begin
                        if (dur_q[i] == DUR_W'(1)) begin
                            state_q[i] <= IDLE;
                            busy[i]    <= 1'b0;
                        end else begin
                            dur_q[i] <= dur_q[i] - DUR_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Signed sum of every playing voice at its current polarity.
    always_comb begin
        mix_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (state_q[i] == PLAY) begin
                if (pol_q[i]) begin
                    mix_next = mix_next + $signed({{(MIX_W-AMP_W){1'b0}}, amp_q[i]});
                end else begin
                    mix_next = mix_next - $signed({{(MIX_W-AMP_W){1'b0}}, amp_q[i]});
                end
            end
        end
    end

    // Register the mix so the output adder sees a stable value; mute silences tones only.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mix_reg <= '0;
        end else if (mute) begin
            mix_reg <= '0;
        end else begin
            mix_reg <= mix_next;
        end
    end

    // Passthrough plus tone mix, widened by one bit so overflow can be clamped.
    always_comb begin
        left_sum  = $signed({{(SUM_W-SAMPLE_W){audio_bus.left_channel_audio_in[SAMPLE_W-1]}},
                             audio_bus.left_channel_audio_in})
                  + $signed({{(SUM_W-MIX_W){mix_reg[MIX_W-1]}}, mix_reg});
        right_sum = $signed({{(SUM_W-SAMPLE_W){audio_bus.right_channel_audio_in[SAMPLE_W-1]}},
                             audio_bus.right_channel_audio_in})
                  + $signed({{(SUM_W-MIX_W){mix_reg[MIX_W-1]}}, mix_reg});
        audio_bus.left_channel_audio_out  = saturate(left_sum);
        audio_bus.right_channel_audio_out = saturate(right_sum);
    end

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Self-checking bench for audio_tone_mixer: a sample-level tone model runs
// beside the design and every cycle's outputs are compared against it, with
// hand-computed spot values at key points of each directed scenario.
module tb_audio_tone_mixer;

    localparam int NV = 4;
    localparam int PW = 19;
    localparam int DW = 16;
    localparam int AW = 24;

    logic                 CLOCK_50;
    logic                 resetn;
    logic [NV-1:0]        trig;
    logic [NV*PW-1:0]     half_period;
    logic [NV*DW-1:0]     duration;
    logic [NV*AW-1:0]     amplitude;
    logic                 mute;
    logic [NV-1:0]        busy;

    audio_tone_mixer_if #(.SAMPLE_W(32)) bus ();

    audio_tone_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(32), .PERIOD_W(PW), .DUR_W(DW), .AMP_W(AW)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .trig        (trig),
        .half_period (half_period),
        .duration    (duration),
        .amplitude   (amplitude),
        .mute        (mute),
        .busy        (busy),
        .audio_bus   (bus)
    );

    int check_count = 0;
    int pass_count  = 0;
    bit checking    = 0;

    // Tone model: each voice remembers when it started, how many samples remain,
    // and its pitch/amplitude; polarity follows from elapsed time alone.
    bit     m_active    [NV];
    int     m_elapsed   [NV];
    int     m_remaining [NV];
    int     m_hp        [NV];
    longint m_amp       [NV];
    longint m_mix = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_elapsed[i] = 0; m_remaining[i] = 0; m_hp[i] = 0; m_amp[i] = 0;
        end
        forever begin
            @(posedge CLOCK_50 or negedge resetn);
            if (!resetn) begin
                for (int i = 0; i < NV; i++) m_active[i] = 0;
                m_mix = 0;
            end else begin
                longint sum;
                bit     x;
                sum = 0;
                for (int i = 0; i < NV; i++) begin
                    if (m_active[i]) begin
                        if (((m_elapsed[i] / (m_hp[i] + 1)) % 2) == 0) sum += m_amp[i];
                        else sum -= m_amp[i];
                    end
                end
                m_mix = mute ? 0 : sum;
                x = bus.audio_in_available & bus.audio_out_allowed;
                for (int i = 0; i < NV; i++) begin
                    if (trig[i]) begin
                        if (duration[i*DW +: DW] != 0) begin
                            m_active[i]    = 1;
                            m_elapsed[i]   = 0;
                            m_remaining[i] = int'(duration[i*DW +: DW]);
                            m_hp[i]        = int'(half_period[i*PW +: PW]);
                            m_amp[i]       = longint'(amplitude[i*AW +: AW]);
                        end else begin
                            m_active[i] = 0;
                        end
                    end else if (m_active[i]) begin
                        m_elapsed[i]++;
                        if (x) begin
                            m_remaining[i]--;
                            if (m_remaining[i] == 0) m_active[i] = 0;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (checking) begin
                logic [NV-1:0] busy_exp;
                logic          x_exp;
                for (int i = 0; i < NV; i++) busy_exp[i] = m_active[i];
                x_exp = bus.audio_in_available & bus.audio_out_allowed & resetn;
                check_output("read",  longint'(bus.read_audio_in),   longint'(x_exp));
                check_output("write", longint'(bus.write_audio_out), longint'(x_exp));
                check_output("busy",  longint'(busy), longint'(busy_exp));
                check_output("left",  longint'(bus.left_channel_audio_out),
                             sat32(longint'(bus.left_channel_audio_in) + m_mix));
                check_output("right", longint'(bus.right_channel_audio_out),
                             sat32(longint'(bus.right_channel_audio_in) + m_mix));
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic sample();
        @(negedge CLOCK_50);
    endtask

    task automatic apply_stimulus(input int v, input int hp, input int dur, input int amp);
        half_period[v*PW +: PW] = PW'(hp);
        duration[v*DW +: DW]    = DW'(dur);
        amplitude[v*AW +: AW]   = AW'(amp);
        trig[v]                 = 1'b1;
    endtask

    initial begin
        resetn = 1'b1; trig = '0; half_period = '0; duration = '0; amplitude = '0; mute = 1'b0;
        bus.audio_in_available = 1'b1; bus.audio_out_allowed = 1'b1;
        bus.left_channel_audio_in = 32'sd77; bus.right_channel_audio_in = 32'sd0;
        #1 resetn = 1'b0;
        checking = 1;

        // Reset: no handshake, outputs pass straight through.
        next_cycle(); sample();
        check_output("rst_write", longint'(bus.write_audio_out), 0);
        check_output("rst_busy", longint'(busy), 0);
        check_output("rst_left", longint'(bus.left_channel_audio_out), 77);
        next_cycle(); resetn = 1'b1; bus.left_channel_audio_in = 32'sd0; sample();
        check_output("idle_write", longint'(bus.write_audio_out), 1);
        check_output("idle_left", longint'(bus.left_channel_audio_out), 0);

        // Single tone, hp=3 dur=8 amp=1000.
        next_cycle(); apply_stimulus(0, 3, 8, 1000);
        next_cycle(); trig = '0; sample();
        check_output("t2_busy_on", longint'(busy[0]), 1);
        check_output("t2_c1_left", longint'(bus.left_channel_audio_out), 0);
        next_cycle(); sample();
        check_output("t2_pos", longint'(bus.left_channel_audio_out), 1000);
        cycles(4); sample();
        check_output("t2_neg", longint'(bus.left_channel_audio_out), -1000);
        cycles(3); sample();
        check_output("t2_busy_off", longint'(busy[0]), 0);
        check_output("t2_last", longint'(bus.left_channel_audio_out), -1000);
        next_cycle(); sample();
        check_output("t2_silent", longint'(bus.left_channel_audio_out), 0);

        // Saturation with two full-scale voices in phase.
        next_cycle(); bus.left_channel_audio_in = 32'sh7FFFFFF0;
        apply_stimulus(0, 4, 20, 24'h7FFFFF); apply_stimulus(1, 4, 20, 24'h7FFFFF);
        next_cycle(); trig = '0;
        next_cycle(); sample();
        check_output("t3_sat_hi", longint'(bus.left_channel_audio_out), 64'sd2147483647);
        check_output("t3_right_pos", longint'(bus.right_channel_audio_out), 16777214);
        cycles(4); bus.left_channel_audio_in = 32'sh80000010;
        cycles(2); sample();
        check_output("t3_sat_lo", longint'(bus.left_channel_audio_out), -64'sd2147483648);
        check_output("t3_right_neg", longint'(bus.right_channel_audio_out), -16777214);
        bus.left_channel_audio_in = 32'sd0;
        cycles(20); sample();
        check_output("t3_done", longint'(busy), 0);

        // Retrigger voice 2 on its fifth sample, then cancel with dur=0.
        next_cycle(); apply_stimulus(2, 1, 10, 500);
        next_cycle(); trig = '0;
        cycles(4); apply_stimulus(2, 1, 3, 500);
        next_cycle(); trig = '0;
        cycles(2); sample();
        check_output("t4_retrig_play", longint'(busy[2]), 1);
        next_cycle(); sample();
        check_output("t4_retrig_end", longint'(busy[2]), 0);
        next_cycle(); apply_stimulus(2, 1, 10, 500);
        next_cycle(); trig = '0;
        cycles(2); sample();
        check_output("t4_play", longint'(busy[2]), 1);
        apply_stimulus(2, 1, 0, 500);
        next_cycle(); trig = '0; sample();
        check_output("t4_cancel", longint'(busy[2]), 0);

        // Output stall freezes the sample count but not the waveform.
        next_cycle(); apply_stimulus(3, 2, 6, 300);
        next_cycle(); trig = '0;
        cycles(2); bus.audio_out_allowed = 1'b0; sample();
        check_output("t5_no_write", longint'(bus.write_audio_out), 0);
        check_output("t5_no_read", longint'(bus.read_audio_in), 0);
        cycles(49); sample();
        check_output("t5_frozen", longint'(busy[3]), 1);
        next_cycle(); bus.audio_out_allowed = 1'b1;
        cycles(3); sample();
        check_output("t5_last", longint'(busy[3]), 1);
        next_cycle(); sample();
        check_output("t5_end", longint'(busy[3]), 0);

        // Reset mid-tone, then mute.
        next_cycle(); apply_stimulus(0, 3, 100, 2000);
        next_cycle(); trig = '0;
        cycles(5);
        bus.left_channel_audio_in = 32'sd12345; bus.right_channel_audio_in = -32'sd5;
        resetn = 1'b0; sample();
        check_output("t6_rst_busy", longint'(busy), 0);
        check_output("t6_rst_write", longint'(bus.write_audio_out), 0);
        check_output("t6_rst_left", longint'(bus.left_channel_audio_out), 12345);
        check_output("t6_rst_right", longint'(bus.right_channel_audio_out), -5);
        next_cycle(); resetn = 1'b1; sample();
        check_output("t6_first_write", longint'(bus.write_audio_out), 1);
        check_output("t6_first_left", longint'(bus.left_channel_audio_out), 12345);
        mute = 1'b1; apply_stimulus(1, 2, 20, 4000);
        next_cycle(); trig = '0;
        next_cycle(); sample();
        check_output("t6_mute_busy", longint'(busy[1]), 1);
        check_output("t6_mute_left", longint'(bus.left_channel_audio_out), 12345);
        check_output("t6_mute_right", longint'(bus.right_channel_audio_out), -5);
        cycles(25); mute = 1'b0;
        cycles(2); sample();
        checking = 0;

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
